// File: rtl/reg_file_pkg.sv
// Shared types and limits for the multi-port register file.
package reg_file_pkg;

  typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;

  localparam int RF_MAX_RD_PORTS = 4;

endpackage

// File: rtl/rf_read_port.sv
// One synchronous read port: range check, zero-register masking and write-first bypass.
module rf_read_port #(
  parameter int D_WIDTH  = 16,
  parameter int A_WIDTH  = 4,
  parameter int REG_NO   = 16,
  parameter int ZERO_REG = 0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               re,
  input  logic [A_WIDTH-1:0] raddr,
  input  logic               wr_ok,
  input  logic [A_WIDTH-1:0] waddr,
  input  logic [D_WIDTH-1:0] wdin,
  input  logic [D_WIDTH-1:0] stored,
  output logic [D_WIDTH-1:0] rdout,
  output logic               rvalid
);

  logic in_range;
  logic zero_hit;
  logic bypass;

  assign in_range = int'(raddr) < REG_NO;
  assign zero_hit = (ZERO_REG != 0) && (raddr == '0);
  // wr_ok already excludes out-of-range and zero-register writes, so no bypass for those
  assign bypass   = wr_ok && (waddr == raddr);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdout  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) begin
        if (!in_range || zero_hit) rdout <= '0;
        else if (bypass)           rdout <= wdin;
        else                       rdout <= stored;
      end
    end
  end

endmodule

// File: rtl/multiport_reg_file.sv
// Register file with one write port, RD_PORTS read ports and a sequential clear engine.
//   state    | meaning
//   RF_IDLE  | normal operation, reads and writes serviced
//   RF_CLEAR | zeroing reg[cnt] each cycle, reads and writes blocked
module multiport_reg_file
  import reg_file_pkg::*;
#(
  parameter int D_WIDTH  = 16,
  parameter int REG_NO   = 16,
  parameter int A_WIDTH  = 4,
  parameter int RD_PORTS = 2,
  parameter int ZERO_REG = 0
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        clr_req,
  output logic                        busy,
  input  logic                        we,
  input  logic [A_WIDTH-1:0]          waddr,
  input  logic [D_WIDTH-1:0]          wdin,
  input  logic [RD_PORTS-1:0]         re,
  input  logic [RD_PORTS*A_WIDTH-1:0] raddr,
  output logic [RD_PORTS*D_WIDTH-1:0] rdout,
  output logic [RD_PORTS-1:0]         rvalid
);

  if (RD_PORTS < 1 || RD_PORTS > RF_MAX_RD_PORTS) begin : g_bad_ports
    $error("RD_PORTS out of range");
  end

  rf_state_t          state, state_nxt;
  logic [A_WIDTH-1:0] cnt, cnt_nxt;
  logic [D_WIDTH-1:0] regs [REG_NO];
  logic               idle;
  logic               wr_ok;

  assign idle  = (state == RF_IDLE);
  assign busy  = ~idle;
  assign wr_ok = we && idle && (int'(waddr) < REG_NO) && !((ZERO_REG != 0) && (waddr == '0));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= RF_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RF_IDLE: begin
        if (clr_req) begin
          state_nxt = RF_CLEAR;
          cnt_nxt   = '0;
        end
      end
      RF_CLEAR: begin
        // terminal compare before increment keeps REG_NO == 2**A_WIDTH from wrapping
        if (cnt == A_WIDTH'(REG_NO - 1)) begin
          state_nxt = RF_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = RF_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < REG_NO; r++) regs[r] <= '0;
    end else begin
      for (int r = 0; r < REG_NO; r++) begin
        if (!idle && (cnt == A_WIDTH'(r)))          regs[r] <= '0;
        else if (wr_ok && (waddr == A_WIDTH'(r)))   regs[r] <= wdin;
      end
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [A_WIDTH-1:0] ra;
    logic [D_WIDTH-1:0] stored;

    assign ra = raddr[p*A_WIDTH +: A_WIDTH];

    always_comb begin
      stored = '0;
      for (int r = 0; r < REG_NO; r++) begin
        if (ra == A_WIDTH'(r)) stored = regs[r];
      end
    end

    rf_read_port #(
      .D_WIDTH (D_WIDTH),
      .A_WIDTH (A_WIDTH),
      .REG_NO  (REG_NO),
      .ZERO_REG(ZERO_REG)
    ) u_port (
      .clk   (clk),
      .rstn  (rstn),
      .re    (re[p] & idle),
      .raddr (ra),
      .wr_ok (wr_ok),
      .waddr (waddr),
      .wdin  (wdin),
      .stored(stored),
      .rdout (rdout[p*D_WIDTH +: D_WIDTH]),
      .rvalid(rvalid[p])
    );
  end

endmodule
